input_strobe_fifo: RTL

//  Device-side front end feeding the CPU input port register (drives its inputUnit D bus).
//  - Accepts 32-bit words from an external device via a 4-phase strobe/ack handshake.
//  - Buffers the words in a small FIFO and presents the oldest word to the port.
//  - CPU IN instruction pops one word per in_rd pulse.

---
 rtl/input_strobe_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/input_strobe_fifo.sv
// Device strobe/ack front end buffering words in a FIFO for the CPU input port.
// Define IN_STROBE_SYNC_EN to pass dev_strobe through a 2-flop synchroniser.
module input_strobe_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] dev_data,
    input  logic             dev_strobe,
    output logic             dev_ack,
    input  logic             in_rd,
    output logic [WIDTH-1:0] inputUnit,
    output logic             in_ready,
    output logic             in_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        IDLE     = 2'd1,
        ACK      = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             strb_s;
    logic             strb_ok;
    logic             push;
    logic             pop;

`ifdef IN_STROBE_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sv_q;

    // sv_q marks when sync_q again reflects the live strobe after a clear,
    // so RST_WAIT cannot be fooled by the zeros left in the synchroniser.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q <= '0;
            sv_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], dev_strobe};
            sv_q   <= {sv_q[0], 1'b1};
        end
    end

    assign strb_s  = sync_q[1];
    assign strb_ok = sv_q[1];
`else
    assign strb_s  = dev_strobe;
    assign strb_ok = 1'b1;
`endif

    assign in_ready  = (count_q != '0);
    assign in_full   = (count_q == CW'(DEPTH));
    assign dev_ack   = (state_q == ACK);
    assign inputUnit = in_ready ? mem_q[rd_ptr_q] : '0;
    assign pop       = in_rd && in_ready;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            RST_WAIT: begin
                if (!strb_s && strb_ok) state_d = IDLE;
            end
            IDLE: begin
                if (strb_s && !in_full) begin
                    push    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!strb_s) state_d = IDLE;
            end
            default: state_d = RST_WAIT;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= RST_WAIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no clear: the head is gated by count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dev_data;
    end

endmodule
